axi_fifo_delay_ctrl: RTL
========================

// Module: axi_fifo_delay_ctrl
// PURPOSE
//  Sequences run-time delay changes on the programmable-delay AXI-Stream FIFO.
//  Sits in front of the FIFO: gates its input, drains in-flight words, applies a new delay, then reopens.
//  A delay change is never applied while words are pending, unless the drain times out.
// PARAMETERS
//  DATA_WIDTH     32   stream data width, passed through to the FIFO
//  DELAY_WIDTH    9    width of the FIFO delay control
//  INIT_DELAY     0    value driven on fifo_delay after reset
//  CNT_WIDTH      10   pending-word counter width; must be at least FIFO ADDR_WIDTH+2
//  DRAIN_TIMEOUT  255  maximum DRAIN cycles before a forced apply
//  GUARD_CYCLES   4    post-apply hold cycles, minimum 1 (covers the FIFO's 3-cycle read latency)
// PORTS
//  clk             in   1            clock
//  async_reset     in   1            asynchronous reset, active-high
//  cfg_valid       in   1            delay update request
//  cfg_delay       in   DELAY_WIDTH  requested delay
//  cfg_ready       out  1            update accepted when cfg_valid & cfg_ready
//  s_axis_tvalid   in   1            upstream stream valid
//  s_axis_tdata    in   DATA_WIDTH   upstream stream data
//  s_axis_tready   out  1            upstream ready = fifo_s_tready & gate_open
//  fifo_s_tvalid   out  1            to FIFO = s_axis_tvalid & gate_open
//  fifo_s_tdata    out  DATA_WIDTH   to FIFO = s_axis_tdata
//  fifo_s_tready   in   1            FIFO input ready
//  fifo_m_tvalid   in   1            FIFO output valid (monitor only)
//  fifo_m_tready   in   1            FIFO output ready (monitor only)
//  fifo_delay      out  DELAY_WIDTH  registered delay to FIFO
//  fifo_sync_reset out  1            registered synchronous reset to FIFO
//  busy            out  1            high in any state other than IDLE
//  cur_delay       out  DELAY_WIDTH  equals fifo_delay
//  timeout_err     out  1            sticky drain-timeout flag
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, gate_open=1, pending=0, timer=0, fifo_delay=INIT_DELAY.
//  Reset (cont.): timeout_err=0, fifo_sync_reset=1; fifo_sync_reset clears on the first clk after release.
//  pending: +1 on fifo_s_tvalid&fifo_s_tready; -1 on fifo_m_tvalid&fifo_m_tready.
//  pending: both events in one cycle = no change; saturates at 0, never wraps.
//  cfg_ready = (state==IDLE), combinational.
//  A write in the accept cycle is still counted; the gate closes from the next cycle.
//  IDLE: on accept with cfg_delay==fifo_delay -> stay IDLE as a no-op; timeout_err is not cleared.
//  IDLE: on accept with a new delay -> latch new_delay, gate_open<=0, timer<=0, timeout_err<=0, go to DRAIN.
//  DRAIN: pending==0 -> APPLY.
//  DRAIN: else if timer==DRAIN_TIMEOUT-1 -> timeout_err<=1, go to APPLY.
//  DRAIN: else timer+1. The pending check takes priority over timeout in the same cycle.
//  APPLY (1 cycle): fifo_delay<=new_delay; flush per CONFIGURATION; timer<=0; go to GUARD.
//  GUARD: hold gate_open=0 for GUARD_CYCLES cycles; then gate_open<=1 and go to IDLE.
//  Latency: accept to fifo_delay update = drain cycles + 1.
//  Latency: accept to gate reopen = drain cycles + 1 + GUARD_CYCLES.
//  cfg_valid outside IDLE is ignored (not accepted); requesters hold it until cfg_ready.
//  The stream is lossless: a gated upstream word stays stalled, never dropped.
//  fifo_m_* are observed only; the downstream side keeps draining the FIFO during DRAIN.
// CONFIGURATION
//  DELAY_CTRL_FLUSH_EN defined:
//   - APPLY drives fifo_sync_reset=1 for exactly 1 cycle; pending<=0 in the same cycle.
//   - Timed-out residual words are discarded.
//  DELAY_CTRL_FLUSH_EN undefined:
//   - fifo_sync_reset is asserted only by async_reset.
//   - After a timeout, residual words stay in the FIFO and pending keeps tracking them.
// TESTING
//  T1 reset: after release fifo_delay=INIT_DELAY, cfg_ready=1, s_axis_tready follows fifo_s_tready.
//  T1 reset (cont.): fifo_sync_reset high for exactly 1 clk after release.
//  T2 idle update: pending=0, cfg_delay=9'd20 -> DRAIN 1 clk, fifo_delay=20 on accept+2.
//  T2 idle update (cont.): s_axis_tready low for 1+1+GUARD_CYCLES=6 clk.
//  T3 drain: 5 words in FIFO, fifo_m_tready=1 -> APPLY only after the 5th output handshake.
//  T3 drain (cont.): no upstream word lost; timeout_err stays 0.
//  T4 timeout: 3 words pending, fifo_m_tready=0 -> APPLY after 255 DRAIN clk, timeout_err=1.
//  T4 timeout (cont.): with FLUSH_EN, 1-clk fifo_sync_reset and pending=0; without it, pending=3.
//  T5 no-op/busy: cfg_delay equal to cur_delay -> no gating, busy stays 0.
//  T5 no-op/busy (cont.): cfg_valid during DRAIN -> cfg_ready=0 and the request is not accepted.
//  T6 mid-op reset: assert async_reset in DRAIN -> immediate IDLE, gate_open=1, fifo_delay=INIT_DELAY.
//  T6 mid-op reset (cont.): timeout_err=0.

Source files
------------

// File: rtl/axi_fifo_delay_ctrl.sv
// Delay-change sequencer in front of the programmable-delay AXI-Stream FIFO: gate, drain, apply, guard.
// Optional macro DELAY_CTRL_FLUSH_EN: APPLY pulses fifo_sync_reset_o and discards residual words.
module axi_fifo_delay_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int DELAY_WIDTH   = 9,
    parameter int INIT_DELAY    = 0,
    parameter int CNT_WIDTH     = 10,
    parameter int DRAIN_TIMEOUT = 255,
    parameter int GUARD_CYCLES  = 4
) (
    input  logic                   clk_i,
    input  logic                   async_reset_i,
    input  logic                   cfg_valid_i,
    input  logic [DELAY_WIDTH-1:0] cfg_delay_i,
    output logic                   cfg_ready_o,
    input  logic                   s_axis_tvalid_i,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata_i,
    output logic                   s_axis_tready_o,
    output logic                   fifo_s_tvalid_o,
    output logic [DATA_WIDTH-1:0]  fifo_s_tdata_o,
    input  logic                   fifo_s_tready_i,
    input  logic                   fifo_m_tvalid_i,
    input  logic                   fifo_m_tready_i,
    output logic [DELAY_WIDTH-1:0] fifo_delay_o,
    output logic                   fifo_sync_reset_o,
    output logic                   busy_o,
    output logic [DELAY_WIDTH-1:0] cur_delay_o,
    output logic                   timeout_err_o,
    output logic [1:0]             dbg_state_o
);
    localparam int TMAX    = (DRAIN_TIMEOUT > GUARD_CYCLES) ? DRAIN_TIMEOUT : GUARD_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_APPLY, ST_GUARD} state_e;

    state_e                 state_q, state_d;
    logic                   gate_open_q, gate_open_d;
    logic [CNT_WIDTH-1:0]   pending_q, pending_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [DELAY_WIDTH-1:0] new_delay_q, new_delay_d;
    logic [DELAY_WIDTH-1:0] fifo_delay_q, fifo_delay_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   fifo_sync_reset_q, fifo_sync_reset_d;
    logic                   wr_hs, rd_hs;

    // Every channel transfers on a cycle where valid & ready are both high; valid never waits on ready.
    assign cfg_ready_o       = (state_q == ST_IDLE);
    assign s_axis_tready_o   = fifo_s_tready_i & gate_open_q;
    assign fifo_s_tvalid_o   = s_axis_tvalid_i & gate_open_q;
    assign fifo_s_tdata_o    = s_axis_tdata_i;
    assign fifo_delay_o      = fifo_delay_q;
    assign cur_delay_o       = fifo_delay_q;
    assign fifo_sync_reset_o = fifo_sync_reset_q;
    assign timeout_err_o     = timeout_err_q;
    assign busy_o            = (state_q != ST_IDLE);
    assign dbg_state_o       = state_q;

    assign wr_hs = fifo_s_tvalid_o & fifo_s_tready_i;
    assign rd_hs = fifo_m_tvalid_i & fifo_m_tready_i;

    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            state_q           <= ST_IDLE;
            gate_open_q       <= 1'b1;
            pending_q         <= '0;
            timer_q           <= '0;
            new_delay_q       <= DELAY_WIDTH'(INIT_DELAY);
            fifo_delay_q      <= DELAY_WIDTH'(INIT_DELAY);
            timeout_err_q     <= 1'b0;
            fifo_sync_reset_q <= 1'b1;
        end else begin
            state_q           <= state_d;
            gate_open_q       <= gate_open_d;
            pending_q         <= pending_d;
            timer_q           <= timer_d;
            new_delay_q       <= new_delay_d;
            fifo_delay_q      <= fifo_delay_d;
            timeout_err_q     <= timeout_err_d;
            fifo_sync_reset_q <= fifo_sync_reset_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        gate_open_d       = gate_open_q;
        pending_d         = pending_q;
        timer_d           = timer_q;
        new_delay_d       = new_delay_q;
        fifo_delay_d      = fifo_delay_q;
        timeout_err_d     = timeout_err_q;
        fifo_sync_reset_d = 1'b0;

        // Occupancy tracker saturates at both ends rather than wrapping.
        if (wr_hs && !rd_hs && (pending_q != '1)) begin
            pending_d = pending_q + CNT_WIDTH'(1);
        end else if (rd_hs && !wr_hs && (pending_q != '0)) begin
            pending_d = pending_q - CNT_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid_i && (cfg_delay_i != fifo_delay_q)) begin
                    new_delay_d   = cfg_delay_i;
                    gate_open_d   = 1'b0;
                    timer_d       = '0;
                    timeout_err_d = 1'b0;
                    state_d       = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pending_q == '0) begin
                    state_d = ST_APPLY;
                end else if (timer_q == TIMER_W'(DRAIN_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_APPLY;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_APPLY: begin
                fifo_delay_d = new_delay_q;
                timer_d      = '0;
                state_d      = ST_GUARD;
`ifdef DELAY_CTRL_FLUSH_EN
                fifo_sync_reset_d = 1'b1;
                pending_d         = '0;
`endif
            end
            ST_GUARD: begin
                if (timer_q == TIMER_W'(GUARD_CYCLES - 1)) begin
                    gate_open_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule
